// File: rtl/branch_ctrl.sv
// Branch resolution controller: evaluates one conditional branch at a time, redirects fetch, then flushes.
// Optional BRANCH_PREDICT_EN adds in_pred_taken/mispredict and redirects only on mispredict.
module branch_ctrl #(
    parameter int OP_W         = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [31:0]     in_pc,
    input  logic [31:0]     in_imm,
    input  logic [31:0]     in_rs1_data,
    input  logic [31:0]     in_rs2_data,
`ifdef BRANCH_PREDICT_EN
    input  logic            in_pred_taken,
    output logic            mispredict,
`endif
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc,
    input  logic            redirect_ack,
    output logic            flush,
    output logic            resolved_valid,
    output logic            resolved_taken,
    output logic            misalign
);

    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_BLT  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BGE  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BLTU = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BGEU = OP_W'(6);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_REDIRECT,
        S_FLUSH
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [OP_W-1:0] r_op;
    logic [31:0]     r_pc;
    logic [30:0]     r_imm;
    logic [31:0]     r_x;
    logic [31:0]     r_y;
    logic [31:0]     r_redir_pc;
    logic [3:0]      r_cnt;

    logic            w_accept;
    logic            w_taken;
    logic [31:0]     w_target;
    logic            w_misalign;
    logic            w_do_redirect;
    logic [31:0]     w_redir_target;
    logic            w_unused_imm_msb;

    assign w_unused_imm_msb = in_imm[31];
    assign w_accept         = in_valid && in_ready;

    always_comb begin
        w_taken = 1'b0;
        case (r_op)
            OP_BEQ:  w_taken = (r_x == r_y);
            OP_BNE:  w_taken = (r_x != r_y);
            OP_BLT:  w_taken = ($signed(r_x) <  $signed(r_y));
            OP_BGE:  w_taken = ($signed(r_x) >= $signed(r_y));
            OP_BLTU: w_taken = (r_x <  r_y);
            OP_BGEU: w_taken = (r_x >= r_y);
            default: w_taken = 1'b0;
        endcase
    end

    assign w_target   = r_pc + {r_imm, 1'b0};
    assign w_misalign = w_taken && (w_target[1:0] != 2'b00);

`ifdef BRANCH_PREDICT_EN
    logic r_pred;

    // Fall-through recovery goes to pc+4, which is always aligned.
    always_comb begin
        w_do_redirect  = 1'b0;
        w_redir_target = w_target;
        if (r_pred && !w_taken) begin
            w_do_redirect  = 1'b1;
            w_redir_target = r_pc + 32'd4;
        end else if (!r_pred && w_taken && !w_misalign) begin
            w_do_redirect  = 1'b1;
        end
    end

    assign mispredict = (r_state == S_EVAL) && (r_pred != w_taken);

    always_ff @(posedge clk) begin
        if (rst)
            r_pred <= 1'b0;
        else if (w_accept)
            r_pred <= in_pred_taken;
    end
`else
    assign w_do_redirect  = w_taken && !w_misalign;
    assign w_redir_target = w_target;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_next_state = S_EVAL;
            S_EVAL:     w_next_state = w_do_redirect ? S_REDIRECT : S_IDLE;
            S_REDIRECT: if (redirect_ack) w_next_state = S_FLUSH;
            S_FLUSH:    if (r_cnt == 4'd1) w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    assign in_ready       = (r_state == S_IDLE) && !rst;
    assign resolved_valid = (r_state == S_EVAL);
    assign resolved_taken = (r_state == S_EVAL) && w_taken;
    assign misalign       = (r_state == S_EVAL) && w_misalign;
    assign redirect_valid = (r_state == S_REDIRECT);
    assign redirect_pc    = (r_state == S_REDIRECT) ? r_redir_pc : 32'd0;
    assign flush          = (r_state == S_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_pc       <= '0;
            r_imm      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_redir_pc <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op  <= in_op;
                r_pc  <= in_pc;
                r_imm <= in_imm[30:0];
                r_x   <= in_rs1_data;
                r_y   <= in_rs2_data;
            end
            if (r_state == S_EVAL)
                r_redir_pc <= w_redir_target;
            // Counter holds the flush cycles still to go, including the current one.
            if (r_state == S_REDIRECT && redirect_ack)
                r_cnt <= 4'(FLUSH_CYCLES);
            else if (r_state == S_FLUSH)
                r_cnt <= r_cnt - 4'd1;
        end
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequences resolution of conditional branches delivered by the B-type decode path (op, imm, rs1/rs2 data, PC).
- Evaluates the branch condition and computes the target.
- Drives a redirect handshake to fetch, then a timed flush of younger instructions.
- Single outstanding branch; backpressures dispatch while busy.

Parameters:
- OP_W, 6, width of the operation code bus.
- FLUSH_CYCLES, 2, cycles `flush` is held after a redirect is acknowledged (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  dispatch presents a branch
- in_ready  out  1  controller can accept
- in_op  in  OP_W  OP_BEQ/BNE/BLT/BGE/BLTU/BGEU/NOP
- in_pc  in  32  PC of branch
- in_imm  in  32  sign-extended halfword offset (target = pc + (imm<<1))
- in_rs1_data  in  32  operand x
- in_rs2_data  in  32  operand y
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target
- redirect_ack  in  1  fetch accepts redirect
- flush  out  1  kill younger in-flight instructions
- resolved_valid  out  1  one-cycle pulse: branch resolved
- resolved_taken  out  1  outcome, valid with resolved_valid
- misalign  out  1  one-cycle pulse: taken target not 4-byte aligned

Behaviour:
- Reset is synchronous, active-high, and overrides everything. Result: state IDLE, counter 0, all outputs 0 except in_ready=0 during rst and 1 in the first cycle after.
- in_ready = 1 only in IDLE. Accept occurs when in_valid && in_ready; in_op/pc/imm/rs1/rs2 are registered on accept.
- States:
  - IDLE: wait for accept → EVAL.
  - EVAL (1 cycle):
    - Compute taken: BEQ x==y, BNE x!=y, BLT/BGE signed, BLTU/BGEU unsigned.
    - NOP or unknown op → taken=0.
    - target = pc + {imm[30:0],1'b0}, 32-bit wrap-around, carry discarded.
    - Pulse resolved_valid with resolved_taken=taken.
    - Not taken → IDLE.
    - Taken with target[1:0]!=0 → pulse misalign, no redirect, → IDLE.
    - Otherwise → REDIRECT.
  - REDIRECT:
    - redirect_valid=1 and redirect_pc=target, stable until redirect_ack.
    - Ack in the first REDIRECT cycle is legal.
    - On ack → FLUSH, counter loaded with FLUSH_CYCLES.
  - FLUSH:
    - flush=1 each cycle; counter decrements.
    - Leaving when counter reaches 1 → IDLE. flush is high exactly FLUSH_CYCLES cycles.
- Latency:
  - Accept at cycle N → resolved_valid at N+1; redirect_valid first high at N+2.
  - Earliest next accept: not-taken N+2; taken with immediate ack N+3+FLUSH_CYCLES.
- redirect_ack outside REDIRECT is ignored. in_valid while busy is held off; no input is lost.
- rst mid-REDIRECT/FLUSH drops redirect_valid and flush the next cycle; no pending state survives.
- Operands are sampled at accept only; later input changes have no effect.

Optional Feature:
- Macro BRANCH_PREDICT_EN.
- Defined:
  - Adds port in_pred_taken (in, 1), registered on accept.
  - Redirect only on mispredict.
  - Predicted taken, actually taken: no redirect, → IDLE.
  - Predicted not taken, actually taken: redirect to target.
  - Predicted taken, actually not taken: redirect to pc+4 (32-bit wrap), misalign check not applied.
  - Predicted not taken, actually not taken: no redirect.
  - resolved_taken still reports the actual outcome. Adds output mispredict (1) pulsed with resolved_valid.
- Undefined: no such ports; every taken branch redirects as above.

Test Plan:
- BEQ, x=y=0x5, pc=0x1000, imm=0x8 → resolved_taken=1 at N+1; redirect_pc=0x1010 at N+2; ack → flush high 2 cycles; in_ready at end.
- BLT x=0xFFFFFFFF, y=1 → taken. BLTU same operands → not taken, no redirect, in_ready back at N+2.
- Taken BNE with pc=0x1000, imm=0x1 (target 0x1002) → misalign pulse at N+1, redirect_valid never asserted.
- Taken branch, ack withheld 5 cycles → redirect_valid/pc stable 5 cycles, in_ready=0; in_valid held throughout → accepted only after flush completes.
- pc=0xFFFFFFF0, imm=0x10 → redirect_pc=0x00000010 (wrap). rst during FLUSH → flush=0 next cycle, in_ready=1 the cycle after rst drops.
- BRANCH_PREDICT_EN: BGE not taken with pred=1, pc=0x2000 → mispredict=1, redirect_pc=0x2004. Taken with pred=1 → no redirect.
